// File: rtl/video_adapter_pkg.sv
// Shared types and constants for the video output adapter: output mode,
// detection FSM states, the M5Display pin permutation and the video bundle.
package video_adapter_pkg;

  localparam int PIXEL_WIDTH  = 24;
  localparam int M5_PERM_BASE = 14;
  localparam int M5_PERM_LEN  = 10;

  // Destination output bit for input bit M5_PERM_BASE + index.
  localparam int M5_PERM [M5_PERM_LEN] = '{18, 23, 17, 22, 16, 21, 15, 20, 14, 19};

  typedef enum logic {
    MODE_ATOM = 1'b0,
    MODE_M5   = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    SAMPLE   = 2'd0,
    DEBOUNCE = 2'd1,
    LOCKED   = 2'd2
  } det_state_e;

  typedef struct packed {
    logic [PIXEL_WIDTH-1:0] pixel;
    logic                   hsync;
    logic                   vsync;
    logic                   de;
  } video_t;

endpackage

// File: rtl/strap_mode_detector.sv
// Board-strap mode detection: 2-FF synchronizer followed by a
// SAMPLE/DEBOUNCE/LOCKED FSM with a saturating stability counter.
module strap_mode_detector
  import video_adapter_pkg::*;
#(
  parameter int STRAP_WIDTH     = 1,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [STRAP_WIDTH-1:0] strap,
  input  logic                   redetect,
  output logic                   mode,
  output logic                   locked
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [STRAP_WIDTH-1:0] sync_meta;
  logic [STRAP_WIDTH-1:0] sync_strap;
  logic [STRAP_WIDTH-1:0] capture;
  logic [1:0]             fill;
  logic [CNT_W-1:0]       count;
  det_state_e             state;
  mode_e                  mode_reg;
  logic                   locked_reg;

  // Two-flop synchronizer; fill marks when its contents reflect real strap samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta  <= '0;
      sync_strap <= '0;
      fill       <= '0;
    end else begin
      sync_meta  <= strap;
      sync_strap <= sync_meta;
      fill       <= {fill[0], 1'b1};
    end
  end

  // Detection FSM: capture, require DEBOUNCE_CYCLES stable samples, then latch the mode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SAMPLE;
      capture    <= '0;
      count      <= '0;
      mode_reg   <= MODE_ATOM;
      locked_reg <= 1'b0;
    end else if (redetect) begin
      state      <= SAMPLE;
      locked_reg <= 1'b0;
    end else begin
      case (state)
        SAMPLE: begin
          // Hold off until the synchronizer no longer shows its reset value.
          if (fill[1]) begin
            capture <= sync_strap;
            count   <= '0;
            state   <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (sync_strap != capture) begin
            capture <= sync_strap;
            count   <= '0;
          end else if (count == CNT_LAST) begin
            state      <= LOCKED;
            locked_reg <= 1'b1;
            mode_reg   <= capture[0] ? MODE_ATOM : MODE_M5;
          end else begin
            count <= count + 1'b1;
          end
        end
        LOCKED:  state <= LOCKED;
        default: state <= SAMPLE;
      endcase
    end
  end

  assign mode   = mode_reg;
  assign locked = locked_reg;

endmodule

// File: rtl/video_output_adapter.sv
// Video output adapter: strap-detected pin mapping (AtomDisplay / M5Display)
// followed by a PIPE_STAGES-deep output register pipeline.
// Optional feature macro VIDEO_OUTPUT_ADAPTER_FORCE_MODE_EN adds force_en /
// force_mode inputs that override the detected mode and lock immediately.
module video_output_adapter
  import video_adapter_pkg::*;
#(
  parameter int   STRAP_WIDTH     = 1,
  parameter int   DEBOUNCE_CYCLES = 1024,
  parameter int   PIPE_STAGES     = 1,
  parameter logic SYNC_ACTIVE     = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [STRAP_WIDTH-1:0] strap,
  input  logic                   redetect,
`ifdef VIDEO_OUTPUT_ADAPTER_FORCE_MODE_EN
  input  logic                   force_en,
  input  logic                   force_mode,
`endif
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   de_in,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   de_out,
  output logic                   mode,
  output logic                   locked
);

  localparam video_t BLANK = '{pixel: '0, hsync: !SYNC_ACTIVE, vsync: !SYNC_ACTIVE, de: 1'b0};

  logic                   det_mode;
  logic                   det_locked;
  logic                   eff_mode;
  logic                   eff_locked;
  logic [PIXEL_WIDTH-1:0] m5_pixel;
  video_t                 stage_in;
  video_t                 stage_q [PIPE_STAGES];

  strap_mode_detector #(
    .STRAP_WIDTH    (STRAP_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_detector (
    .clock   (clock),
    .reset_n (reset_n),
    .strap   (strap),
    .redetect(redetect),
    .mode    (det_mode),
    .locked  (det_locked)
  );

`ifdef VIDEO_OUTPUT_ADAPTER_FORCE_MODE_EN
  assign eff_locked = force_en | det_locked;
  assign eff_mode   = force_en ? force_mode : det_mode;
`else
  assign eff_locked = det_locked;
  assign eff_mode   = det_mode;
`endif

  assign mode   = eff_mode;
  assign locked = eff_locked;

  // M5Display wiring: low bits straight, upper ten bits scattered by the table.
  assign m5_pixel[M5_PERM_BASE-1:0] = pixel_in[M5_PERM_BASE-1:0];
  genvar gi;
  generate
    for (gi = 0; gi < M5_PERM_LEN; gi++) begin : g_perm
      assign m5_pixel[M5_PERM[gi]] = pixel_in[M5_PERM_BASE + gi];
    end
  endgenerate

  // Mapping and blanking at the pipeline input so one output word never mixes modes.
  always_comb begin
    stage_in = BLANK;
    if (eff_locked) begin
      stage_in.de = de_in;
      if (eff_mode == MODE_M5) begin
        stage_in.pixel = m5_pixel;
        stage_in.hsync = vsync_in;
        stage_in.vsync = hsync_in;
      end else begin
        stage_in.pixel = pixel_in;
        stage_in.hsync = hsync_in;
        stage_in.vsync = vsync_in;
      end
    end
  end

  generate
    for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First output register stage, loaded from the mapped input.
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) stage_q[gi] <= BLANK;
          else          stage_q[gi] <= stage_in;
        end
      end else begin : g_next
        // Subsequent stage, loaded from the previous one.
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) stage_q[gi] <= BLANK;
          else          stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  assign pixel_out = stage_q[PIPE_STAGES-1].pixel;
  assign hsync_out = stage_q[PIPE_STAGES-1].hsync;
  assign vsync_out = stage_q[PIPE_STAGES-1].vsync;
  assign de_out    = stage_q[PIPE_STAGES-1].de;

endmodule

// File: tb/tb_video_output_adapter.sv
// Self-checking bench for video_output_adapter (DEBOUNCE_CYCLES=16, PIPE_STAGES=3,
// STRAP_WIDTH=2, active-low syncs). A behavioural model tracks lock detection as a
// run of equal synchronized strap samples and the video path as a delay line.
module tb_video_output_adapter;

  localparam int   SW = 2;
  localparam int   D  = 16;
  localparam int   P  = 3;
  localparam logic SA = 1'b0;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [SW-1:0] strap = '0;
  logic          redetect = 1'b0;
  logic [23:0]   pixel_in = '0;
  logic          hsync_in = 1'b0, vsync_in = 1'b0, de_in = 1'b0;
  logic          force_en = 1'b0, force_mode = 1'b0;
  logic [23:0]   pixel_out;
  logic          hsync_out, vsync_out, de_out, mode, locked;

  always #5 clock = ~clock;

  video_output_adapter #(
    .STRAP_WIDTH(SW), .DEBOUNCE_CYCLES(D), .PIPE_STAGES(P), .SYNC_ACTIVE(SA)
  ) dut (
    .clock(clock), .reset_n(reset_n), .strap(strap), .redetect(redetect),
`ifdef VIDEO_OUTPUT_ADAPTER_FORCE_MODE_EN
    .force_en(force_en), .force_mode(force_mode),
`endif
    .pixel_in(pixel_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .mode(mode), .locked(locked)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Behavioural model state
  logic          m_locked, m_mode;
  logic [SW-1:0] m_sy1, m_sy2, m_val;
  int            m_warm, m_run;
  bit            m_sample;
  logic [23:0]   m_pix [P];
  logic          m_hs [P], m_vs [P], m_de [P];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic e_locked();
`ifdef VIDEO_OUTPUT_ADAPTER_FORCE_MODE_EN
    return m_locked | force_en;
`else
    return m_locked;
`endif
  endfunction

  function automatic logic e_mode();
`ifdef VIDEO_OUTPUT_ADAPTER_FORCE_MODE_EN
    return force_en ? force_mode : m_mode;
`else
    return m_mode;
`endif
  endfunction

  // M5 permutation: even entries walk down from bit 18, odd entries down from bit 23.
  function automatic logic [23:0] m5_map(input logic [23:0] p);
    logic [23:0] r;
    int dst;
    r = p;
    for (int i = 0; i < 10; i++) begin
      dst = (i % 2 == 0) ? 18 - i / 2 : 23 - i / 2;
      r[dst] = p[14 + i];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_mode = 0; m_sy1 = '0; m_sy2 = '0; m_val = '0;
    m_warm = 2; m_run = 0; m_sample = 1;
    for (int i = 0; i < P; i++) begin
      m_pix[i] = '0; m_hs[i] = ~SA; m_vs[i] = ~SA; m_de[i] = 1'b0;
    end
  endtask

  // Advance one clock edge: predict post-edge state from current inputs, then commit.
  task automatic tick();
    logic [SW-1:0] s, n_sy1, n_sy2, n_val;
    logic          n_locked, n_mode, in_hs, in_vs, in_de;
    logic [23:0]   in_pix;
    int            n_warm, n_run;
    bit            n_sample;
    n_locked = m_locked; n_mode = m_mode; n_val = m_val;
    n_warm = m_warm; n_run = m_run; n_sample = m_sample;
    s = m_sy2; n_sy1 = strap; n_sy2 = m_sy1;
    if (m_warm > 0) n_warm = m_warm - 1;
    if (redetect) begin
      n_locked = 0; n_sample = 1;
    end else if (m_warm == 0) begin
      if (m_sample) begin
        n_val = s; n_run = 1; n_sample = 0;
      end else if (!m_locked) begin
        if (s == m_val) begin
          n_run = m_run + 1;
          if (n_run == D + 1) begin n_locked = 1; n_mode = ~s[0]; end
        end else begin
          n_val = s; n_run = 1;
        end
      end
    end
    if (e_locked()) begin
      in_de = de_in;
      if (e_mode()) begin in_pix = m5_map(pixel_in); in_hs = vsync_in; in_vs = hsync_in; end
      else          begin in_pix = pixel_in;         in_hs = hsync_in; in_vs = vsync_in; end
    end else begin
      in_pix = '0; in_hs = ~SA; in_vs = ~SA; in_de = 1'b0;
    end
    @(posedge clock);
    m_locked = n_locked; m_mode = n_mode; m_val = n_val; m_warm = n_warm;
    m_run = n_run; m_sample = n_sample; m_sy1 = n_sy1; m_sy2 = n_sy2;
    for (int i = P - 1; i > 0; i--) begin
      m_pix[i] = m_pix[i-1]; m_hs[i] = m_hs[i-1]; m_vs[i] = m_vs[i-1]; m_de[i] = m_de[i-1];
    end
    m_pix[0] = in_pix; m_hs[0] = in_hs; m_vs[0] = in_vs; m_de[0] = in_de;
    #1;
  endtask

  task automatic rand_video();
    pixel_in = 24'($urandom);
    hsync_in = 1'($urandom_range(0, 1));
    vsync_in = 1'($urandom_range(0, 1));
    de_in    = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    redetect = 0;
    reset_n = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset_n = 1;
  endtask

  // Tick with random video until locked rises; t = ticks taken (limit if never).
  task automatic wait_lock(input int limit, output int t);
    t = limit;
    for (int i = 1; i <= limit; i++) begin
      rand_video();
      tick();
      if (locked) begin t = i; break; end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("pixel_out", pixel_out, m_pix[P-1]);
      check("hsync_out", hsync_out, m_hs[P-1]);
      check("vsync_out", vsync_out, m_vs[P-1]);
      check("de_out", de_out, m_de[P-1]);
      check("locked", locked, e_locked());
      check("mode", mode, e_mode());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    strap = 2'b00;
    model_reset();
    chk_en = 1;
    do_reset();

    // Lock from reset: 2 sync + 1 sample + 16 debounce cycles.
    for (int e = 1; e <= 19; e++) begin
      rand_video();
      tick();
      if (e == 18) begin
        check("lock18_locked", locked, 0);
        check("lock18_de_blank", de_out, 0);
        check("lock18_model", m_locked, 0);
      end
    end
    check("lock19_locked", locked, 1);
    check("lock19_mode", mode, 1);
    check("lock19_model", m_locked, 1);

    // M5 mapping literal.
    pixel_in = 24'h00C000; hsync_in = 1; vsync_in = 0; de_in = 1;
    tick();
    for (int i = 0; i < P - 1; i++) begin rand_video(); tick(); end
    check("m5_pixel", pixel_out, 24'h840000);
    check("m5_hsync", hsync_out, 0);
    check("m5_vsync", vsync_out, 1);
    check("m5_model_pixel", m_pix[P-1], 24'h840000);

    // Strap change while locked is ignored.
    strap = 2'b01;
    for (int i = 0; i < 40; i++) begin rand_video(); tick(); end
    check("hold_locked", locked, 1);
    check("hold_mode", mode, 1);

    // Redetect: locked drops next cycle, relocks in mode 0 after 17 cycles.
    redetect = 1; rand_video(); tick(); redetect = 0;
    check("redet_drop", locked, 0);
    wait_lock(100, t);
    check("redet_lock_cycles", t, 17);
    check("redet_mode", mode, 0);

    // Mode-0 passthrough literal.
    pixel_in = 24'hA5F00F; hsync_in = 1; vsync_in = 0; de_in = 1;
    tick();
    for (int i = 0; i < P - 1; i++) begin rand_video(); tick(); end
    check("m0_pixel", pixel_out, 24'hA5F00F);
    check("m0_hsync", hsync_out, 1);
    check("m0_vsync", vsync_out, 0);
    strap = 2'b00;
    for (int i = 0; i < 30; i++) begin rand_video(); tick(); end
    check("m0_hold_mode", mode, 0);

    // Glitch: strap changes 10 cycles after redetect; lock restarts, mode follows new value.
    redetect = 1; rand_video(); tick(); redetect = 0;
    t = 100;
    for (int i = 1; i <= 100; i++) begin
      if (i == 10) strap = 2'b01;
      rand_video();
      tick();
      if (locked) begin t = i; break; end
    end
    check("glitch_lock_cycles", t, 28);
    check("glitch_mode", mode, 0);

    // Redetect colliding with lock completion: redetect wins.
    strap = 2'b10;
    for (int i = 0; i < 4; i++) begin rand_video(); tick(); end
    redetect = 1; rand_video(); tick(); redetect = 0;
    for (int i = 0; i < 16; i++) begin rand_video(); tick(); end
    redetect = 1; rand_video(); tick(); redetect = 0;
    check("collide_locked", locked, 0);
    wait_lock(100, t);
    check("collide_relock", t, 17);
    check("collide_mode", mode, 1);

    // Reset mid-debounce discards progress.
    redetect = 1; rand_video(); tick(); redetect = 0;
    for (int i = 0; i < 8; i++) begin rand_video(); tick(); end
    do_reset();
    wait_lock(100, t);
    check("rst_mid_lock_cycles", t, 19);

`ifdef VIDEO_OUTPUT_ADAPTER_FORCE_MODE_EN
    strap = 2'b00;
    redetect = 1; rand_video(); tick(); redetect = 0;
    force_en = 1; force_mode = 0;
    #1;
    check("force_locked", locked, 1);
    check("force_mode", mode, 0);
    for (int i = 0; i < 8; i++) begin rand_video(); tick(); end
    force_en = 0;
`endif

    // Randomized soak with occasional strap changes, redetects and a reset.
    for (int i = 0; i < 1500; i++) begin
      rand_video();
      if ($urandom_range(0, 29) == 0) strap = SW'($urandom);
      redetect = ($urandom_range(0, 149) == 0);
      tick();
      redetect = 0;
      if (i == 700) do_reset();
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
